ram_dual_clr: RTL and testbench
===============================

RAM_DUAL_CLR -- requirements
Module: ram_dual_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter ADR_WIDTH, default 8, address width in bits.
REQ-003 SHALL have parameter WORD_NUM, default 256, number of words; must satisfy 2 <= WORD_NUM <= 2**ADR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values are 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default "NEW_DATA", read-during-write behaviour; legal values are "NEW_DATA" or "OLD_DATA".
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, which enables the post-reset memory clear.
REQ-007 SHALL have parameter CLEAR_VALUE, default 0, the DATA_WIDTH-bit word written during the clear.
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-010 SHALL have port wr, input, 1 bit, write strobe.
REQ-011 SHALL have port wrAdr, input, ADR_WIDTH bits, write address.
REQ-012 SHALL have port a, input, DATA_WIDTH bits, write data.
REQ-013 SHALL have port rd, input, 1 bit, read strobe.
REQ-014 SHALL have port rdAdr, input, ADR_WIDTH bits, read address.
REQ-015 SHALL have port q, output, DATA_WIDTH bits, read data.
REQ-016 SHALL have port qValid, output, 1 bit, a one-cycle pulse marking valid q.
REQ-017 SHALL have port busy, output, 1 bit, high while the clear is in progress.

Function
REQ-018 SHALL implement a simple dual-port memory: one write port and one read port, usable in the same cycle.
REQ-019 SHALL store the word: wr=1 and busy=0 at edge n writes a to wrAdr.
REQ-020 SHALL return read data with fixed latency: rd=1 and busy=0 at edge n gives q = data and qValid=1 after edge n+RD_LATENCY, for exactly one cycle per accepted read.
REQ-021 SHALL hold q at its last value when no read completes; qValid=0 in those cycles.
REQ-022 SHALL accept back-to-back reads, one per cycle, with no bubbles.
REQ-023 SHALL handle same-cycle wr and rd to the same address: in NEW_DATA mode q = a of that write; in OLD_DATA mode q = the prior contents.
REQ-024 SHALL treat addresses >= WORD_NUM as follows: writes are ignored; reads return q=0 with qValid=1.
REQ-025 SHALL implement the clear FSM with states IDLE and CLEAR; reset (with CLEAR_ON_RESET=1) enters CLEAR with clear counter = 0.
REQ-026 SHALL, in CLEAR, write CLEAR_VALUE to address counter each cycle and increment the counter; at counter = WORD_NUM-1 it writes that address and then goes to IDLE.
REQ-027 SHALL hold busy=1 exactly in CLEAR, for exactly WORD_NUM cycles after reset deasserts.
REQ-028 SHALL ignore wr and rd while busy=1: no write, no qValid.
REQ-029 SHALL, when reset is asserted mid-clear, restart the clear from address 0.
REQ-030 SHALL, when CLEAR_ON_RESET=0, enter IDLE directly from reset with busy=0; memory contents are then undefined until written.
REQ-031 SHALL, on reset during an outstanding read, flush the read pipeline; no qValid pulse results.

Reset
REQ-032 SHALL, while reset=1, drive q=0, qValid=0, read pipeline cleared, clear counter=0, and busy=CLEAR_ON_RESET.
REQ-033 SHALL NOT reset the memory array itself; only the clear sequence initialises it.

Structure
REQ-034 SHALL take the FSM state typedef (IDLE, CLEAR) and the RDW mode string constants from shared package ram_pkg.
REQ-035 SHALL place the clear FSM and counter in sub-module ram_clear_seq, with outputs busy, clrWr and clrAdr.
REQ-036 SHALL use a memory array that is inferable as block RAM; RD_LATENCY=2 adds one output register.

Verification
REQ-037 SHALL cover reset with defaults: busy=1 for 256 cycles, then 0; a subsequent read of address 0x37 returns 0x0000.
REQ-038 SHALL cover write 0xBEEF to 0x10, then read 0x10 the next cycle: q=0xBEEF with qValid pulse 1 cycle after rd (RD_LATENCY=1) or 2 cycles after rd (RD_LATENCY=2).
REQ-039 SHALL cover a same-cycle write of 0x1234 over 0xAAAA at 0x05 with a read of 0x05: q=0x1234 in NEW_DATA mode and q=0xAAAA in OLD_DATA mode.
REQ-040 SHALL cover reset pulsed at clear cycle 100: busy remains 1 for a further 256 cycles; wr of 0x5555 to 0x02 during busy is lost, so a read returns CLEAR_VALUE.
REQ-041 SHALL cover WORD_NUM=200 with a write to 0xF0 followed by a read of 0xF0: q=0 with qValid=1; a streaming read of 0..199 gives 200 consecutive qValid pulses.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with post-reset clear.
// Holds the clear-sequencer state encoding and the read-during-write mode names.
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Read-during-write mode names, compared against the RDW_MODE parameter
    localparam RDW_NEW_DATA = "NEW_DATA";
    localparam RDW_OLD_DATA = "OLD_DATA";

    localparam int unsigned RD_LATENCY_MIN = 32'd1;
    localparam int unsigned RD_LATENCY_MAX = 32'd2;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, writing the
// clear value, and holds busy high while it does so.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADR_WIDTH      = 8,
    parameter int WORD_NUM       = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 busy,
    output logic                 clrWr,
    output logic [ADR_WIDTH-1:0] clrAdr
);

    localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(WORD_NUM - 32'sd1);
    localparam bit                   CLR_EN   = (CLEAR_ON_RESET != 32'sd0);

    clr_state_t           state_r;
    clr_state_t           state_s;
    logic [ADR_WIDTH-1:0] cnt_r;
    logic [ADR_WIDTH-1:0] cnt_s;

    // State and address counter register; reset restarts the walk at address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CLR_EN ? CLEAR : IDLE;
            cnt_r   <= {ADR_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                state_s = IDLE;
                cnt_s   = {ADR_WIDTH{1'b0}};
            end
            CLEAR: begin
                if (cnt_r == LAST_ADR) begin
                    state_s = IDLE;
                    cnt_s   = {ADR_WIDTH{1'b0}};
                end else begin
                    state_s = CLEAR;
                    cnt_s   = cnt_r + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {ADR_WIDTH{1'b0}};
            end
        endcase
    end

    // Outputs; while reset is held busy reflects whether a clear will follow
    always_comb begin
        busy   = 1'b0;
        clrWr  = 1'b0;
        clrAdr = cnt_r;
        if (reset) begin
            busy  = CLR_EN;
            clrWr = 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    busy  = 1'b1;
                    clrWr = 1'b1;
                end
                IDLE: begin
                    busy  = 1'b0;
                    clrWr = 1'b0;
                end
                default: begin
                    busy  = 1'b0;
                    clrWr = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_dual_clr.sv
// Simple dual-port RAM (one write, one read port) with fixed read latency,
// selectable read-during-write behaviour and an optional post-reset clear.
module ram_dual_clr
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADR_WIDTH      = 8,
    parameter int                    WORD_NUM       = 256,
    parameter int                    RD_LATENCY     = 1,
    parameter                        RDW_MODE       = "NEW_DATA",
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [ADR_WIDTH-1:0]  wrAdr,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  rd,
    input  logic [ADR_WIDTH-1:0]  rdAdr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  qValid,
    output logic                  busy
);

    localparam int unsigned           LIM_W     = ADR_WIDTH + 32'sd1;
    localparam logic [ADR_WIDTH:0]    ADR_LIMIT = LIM_W'(WORD_NUM);
    localparam bit                    NEW_MODE  = (RDW_MODE == RDW_NEW_DATA);

    if ((RD_LATENCY < 32'sd1) || (RD_LATENCY > 32'sd2)) begin : g_bad_latency
        $error("ram_dual_clr: RD_LATENCY must be 1 or 2");
    end
    if ((WORD_NUM < 32'sd2) || (WORD_NUM > (32'sd1 <<< ADR_WIDTH))) begin : g_bad_depth
        $error("ram_dual_clr: WORD_NUM out of range for ADR_WIDTH");
    end
    if ((RDW_MODE != RDW_NEW_DATA) && (RDW_MODE != RDW_OLD_DATA)) begin : g_bad_rdw
        $error("ram_dual_clr: RDW_MODE must be NEW_DATA or OLD_DATA");
    end

    logic                  busy_s;
    logic                  clr_wr_s;
    logic [ADR_WIDTH-1:0]  clr_adr_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic                  rd_in_range_s;
    logic                  fwd_s;
    logic                  mem_we_s;
    logic [ADR_WIDTH-1:0]  mem_wa_s;
    logic [DATA_WIDTH-1:0] mem_wd_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] q1_r;
    logic                  v1_r;
    logic [DATA_WIDTH-1:0] mem [WORD_NUM];

    ram_clear_seq #(
        .ADR_WIDTH      (ADR_WIDTH),
        .WORD_NUM       (WORD_NUM),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk    (clk),
        .reset  (reset),
        .busy   (busy_s),
        .clrWr  (clr_wr_s),
        .clrAdr (clr_adr_s)
    );

    assign busy = busy_s;

    // User accesses are only accepted when idle; out-of-range writes are dropped
    always_comb begin
        wr_ok_s       = wr & ~busy_s & ({1'b0, wrAdr} < ADR_LIMIT);
        rd_ok_s       = rd & ~busy_s;
        rd_in_range_s = ({1'b0, rdAdr} < ADR_LIMIT);
        fwd_s         = NEW_MODE & wr_ok_s & (wrAdr == rdAdr);
    end

    // Single write port shared between the clear walker and user writes
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = wrAdr;
        mem_wd_s = a;
        if (clr_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = clr_adr_s;
            mem_wd_s = CLEAR_VALUE;
        end else if (wr_ok_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array, deliberately without reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    // Read word selection: out-of-range reads return zero, NEW_DATA forwards a
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        if (!rd_in_range_s) begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end else if (fwd_s) begin
            rd_data_s = a;
        end else begin
            rd_data_s = mem[rdAdr];
        end
    end

    // First read stage; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            q1_r <= {DATA_WIDTH{1'b0}};
            v1_r <= 1'b0;
        end else begin
            v1_r <= rd_ok_s;
            if (rd_ok_s) begin
                q1_r <= rd_data_s;
            end
        end
    end

    if (RD_LATENCY == 32'sd2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2_r;
        logic                  v2_r;

        // Extra output register stage
        always_ff @(posedge clk) begin
            if (reset) begin
                q2_r <= {DATA_WIDTH{1'b0}};
                v2_r <= 1'b0;
            end else begin
                v2_r <= v1_r;
                if (v1_r) begin
                    q2_r <= q1_r;
                end
            end
        end

        assign q      = q2_r;
        assign qValid = v2_r;
    end else begin : g_lat1
        assign q      = q1_r;
        assign qValid = v1_r;
    end

endmodule

// File: tb/tb_ram_dual_clr.sv
// Scoreboard bench for ram_dual_clr: two instances (latency 1 / NEW_DATA / 256
// words, latency 2 / OLD_DATA / 200 words) driven by the same stimulus.
module tb_ram_dual_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wr;
    logic [7:0]  wrAdr;
    logic [15:0] a;
    logic        rd;
    logic [7:0]  rdAdr;
    logic [1:0][15:0] q_o;
    logic [1:0]       qv_o;
    logic [1:0]       busy_o;

    ram_dual_clr #(
        .DATA_WIDTH(16), .ADR_WIDTH(8), .WORD_NUM(256), .RD_LATENCY(1),
        .RDW_MODE("NEW_DATA"), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
    ) dut0 (
        .clk(clk), .reset(reset), .wr(wr), .wrAdr(wrAdr), .a(a), .rd(rd),
        .rdAdr(rdAdr), .q(q_o[0]), .qValid(qv_o[0]), .busy(busy_o[0])
    );

    ram_dual_clr #(
        .DATA_WIDTH(16), .ADR_WIDTH(8), .WORD_NUM(200), .RD_LATENCY(2),
        .RDW_MODE("OLD_DATA"), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h5A5A)
    ) dut1 (
        .clk(clk), .reset(reset), .wr(wr), .wrAdr(wrAdr), .a(a), .rd(rd),
        .rdAdr(rdAdr), .q(q_o[1]), .qValid(qv_o[1]), .busy(busy_o[1])
    );

    typedef struct {
        int          dut;
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          m_busy [2];
    int          m_cnt  [2];
    logic [15:0] mm     [2][256];
    logic [15:0] last_q [2];

    function automatic int wn(input int d);
        return (d == 0) ? 256 : 200;
    endfunction
    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction
    function automatic logic [15:0] cv(input int d);
        return (d == 0) ? 16'h0000 : 16'h5A5A;
    endfunction
    function automatic bit new_mode(input int d);
        return (d == 0);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs sampled there
    task automatic model_edge();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 1'b1;
                m_cnt[d]  = 0;
                last_q[d] = 16'h0000;
            end else if (m_busy[d]) begin
                mm[d][m_cnt[d]] = cv(d);
                if (m_cnt[d] == wn(d) - 1) m_busy[d] = 1'b0;
                m_cnt[d]++;
            end else begin
                if (rd) begin
                    e.dut = d;
                    e.due = cyc + lat(d) - 1;
                    if (int'(rdAdr) >= wn(d))                        e.data = 16'h0000;
                    else if (wr && wrAdr == rdAdr && new_mode(d))    e.data = a;
                    else                                             e.data = mm[d][rdAdr];
                    sb.push_back(e);
                end
                if (wr && int'(wrAdr) < wn(d)) mm[d][wrAdr] = a;
            end
        end
        if (reset) sb.delete();
    endtask

    task automatic check_outputs();
        int idx;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(m_busy[d]));
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].dut == d) idx = i;
            end
            if (idx >= 0 && sb[idx].due == cyc) begin
                check_eq($sformatf("qValid%0d", d), 32'(qv_o[d]), 32'd1);
                check_eq($sformatf("q%0d", d), 32'(q_o[d]), 32'(sb[idx].data));
                last_q[d] = sb[idx].data;
                sb.delete(idx);
            end else begin
                check_eq($sformatf("qValid%0d", d), 32'(qv_o[d]), 32'd0);
                check_eq($sformatf("qhold%0d", d), 32'(q_o[d]), 32'(last_q[d]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit w, input logic [7:0] wa, input logic [15:0] wd,
                         input bit r, input logic [7:0] ra);
        wr = w; wrAdr = wa; a = wd; rd = r; rdAdr = ra;
        step();
    endtask

    task automatic idle(input int n);
        wr = 1'b0; rd = 1'b0;
        repeat (n) step();
    endtask

    int n0;
    int n1;

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; wrAdr = 8'h00; rdAdr = 8'h00; a = 16'h0000;
        step();
        step();
        reset = 1'b0;

        // Post-reset clear length
        n0 = int'(busy_o[0]); n1 = int'(busy_o[1]);
        for (int i = 0; i < 300; i++) begin
            step();
            n0 += int'(busy_o[0]); n1 += int'(busy_o[1]);
        end
        check_eq("busy_len0", 32'(n0), 32'd256);
        check_eq("busy_len1", 32'(n1), 32'd200);

        drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h37);
        idle(3);
        drive(1'b1, 8'h10, 16'hBEEF, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h10);
        idle(3);
        drive(1'b1, 8'h05, 16'hAAAA, 1'b0, 8'h00);
        drive(1'b1, 8'h05, 16'h1234, 1'b1, 8'h05);
        idle(3);
        drive(1'b1, 8'hF0, 16'h7777, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'hF0);
        idle(3);

        // Back-to-back streaming read of 0..199
        n0 = 0; n1 = 0;
        for (int i = 0; i < 203; i++) begin
            if (i < 200) drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'(i));
            else         idle(1);
            n0 += int'(qv_o[0]); n1 += int'(qv_o[1]);
        end
        check_eq("stream_pulses0", 32'(n0), 32'd200);
        check_eq("stream_pulses1", 32'(n1), 32'd200);

        // Mixed random traffic with frequent same-address collisions
        for (int i = 0; i < 400; i++) begin
            logic [7:0] wa;
            logic [7:0] ra;
            wa = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom);
            drive(1'($urandom), wa, 16'($urandom), 1'($urandom), ra);
        end
        idle(3);

        // Outstanding read flushed by reset, then reset pulsed mid-clear
        drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h03);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(100);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n0 = int'(busy_o[0]); n1 = int'(busy_o[1]);
        for (int i = 0; i < 300; i++) begin
            if (i == 0) drive(1'b1, 8'h02, 16'h5555, 1'b0, 8'h00);
            else        idle(1);
            n0 += int'(busy_o[0]); n1 += int'(busy_o[1]);
        end
        check_eq("busy_restart0", 32'(n0), 32'd256);
        check_eq("busy_restart1", 32'(n1), 32'd200);
        drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h02);
        idle(4);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
